instr_encode_loader: RTL

- Inverse of the core's immediate generator: accepts decoded instruction fields plus a signed immediate, packs them into a 32-bit RV32I instruction word, and streams the words into instruction memory at sequential addresses.
- Used by the test and boot path to load programs into the single-cycle and pipelined cores without an external assembler.
- Range-checks each immediate against its format. Instructions that fail the check are dropped and reported; they are never written.

---
 rtl/instr_encode_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encode_loader.sv
// Packs decoded RV32I fields plus a signed immediate into instruction words
// and streams them into instruction memory at sequential byte addresses.
module instr_encode_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_valid,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [ADDR_W-1:0]  wptr;
  logic [31:0]        enc_word;
  logic               legal;
  logic               accept;
  logic               wr_done;
  logic signed [31:0] simm;

  assign simm    = in_imm;
  assign accept  = in_valid && in_ready;
  assign wr_done = mem_we && mem_ready;

  always_comb begin
    enc_word = '0;
    legal    = 1'b0;
    case (in_fmt)
      3'd0: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal    = 1'b1;
      end
      3'd1: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        legal    = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      end
      3'd2: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal    = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      end
      3'd3: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        legal    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !in_imm[0];
      end
      3'd4: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        legal    = (in_imm[11:0] == 12'd0);
      end
      3'd5: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal    = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A write completing this cycle counts as no longer pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (count == '0) ? DONE : RUN;
      RUN:  if ((remaining == '0) && (!mem_we || mem_ready)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    in_ready = (state == RUN) && (remaining != '0) && (!mem_we || mem_ready);
  end

  // wptr advances when a write is issued; each issued write completes in
  // order, so the address sequence matches advancing on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      wptr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_valid <= 1'b0;
      if (state == IDLE && start) begin
        remaining <= count;
        wptr      <= base_addr;
        err_cnt   <= '0;
      end
      if (wr_done) mem_we <= 1'b0;
      if (accept) begin
        remaining <= remaining - 1'b1;
        if (legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= wptr;
          mem_wdata <= enc_word;
          wptr      <= wptr + ADDR_W'(4);
        end else begin
          err_valid <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
